gcd_binary: RTL and testbench
=============================

GCD_BINARY -- requirements
Module: gcd_binary

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: n1  input  WIDTH  operand A, latched on accepted start.
REQ-006 SHALL have port: n2  input  WIDTH  operand B, latched on accepted start.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  single-cycle pulse when result is valid.
REQ-009 SHALL have port: result  output  WIDTH  gcd(n1,n2), held until next accepted start.
REQ-010 SHALL have port: zero_in  output  1  set with done when n1==0 and n2==0; held with result.

Function
REQ-011 SHALL implement Stein's binary GCD: shifts, compare and subtract only, no divide or modulo.
REQ-012 SHALL use states IDLE, CHECK, STRIP, ODD_A, LOOP, FINISH, DONE.
REQ-013 IDLE: start=1 latches a=n1, b=n2, k=0, clears zero_in, goes to CHECK; start=0 stays in IDLE.
REQ-014 CHECK: a==0 or b==0 -> result=a|b, zero_in=(a|b)==0, DONE; else STRIP.
REQ-015 STRIP: both a and b even -> a>>=1, b>>=1, k+=1, stay; else ODD_A.
REQ-016 ODD_A: a even -> a>>=1, stay; else LOOP.
REQ-017 LOOP: b even -> b>>=1, stay; b==a -> FINISH; a>b -> a<=b, b<=a-b; else b<=b-a; subtract cases stay in LOOP.
REQ-018 FINISH: result = a << k, truncated to WIDTH, then DONE.
REQ-019 DONE: done=1 for exactly this cycle, then IDLE; the next start is accepted no earlier than the cycle after done.
REQ-020 Subtraction SHALL be unsigned WIDTH-bit and SHALL never underflow, because the larger operand is always the minuend.
REQ-021 k SHALL be $clog2(WIDTH)+1 bits wide and SHALL never exceed WIDTH-1.
REQ-022 start asserted while busy SHALL be ignored; operands and in-flight computation SHALL be unaffected.
REQ-023 n1 and n2 changes after acceptance SHALL not affect the computation.
REQ-024 Latency from accepted start to done SHALL be at most 4*WIDTH+4 cycles.
REQ-025 result and zero_in SHALL change only in CHECK or FINISH and SHALL otherwise hold.

Reset
REQ-026 rst SHALL force state IDLE, a=b=0, k=0, result=0, done=0, zero_in=0, busy=0 on the next edge.
REQ-027 rst during any busy state SHALL abort the operation and SHALL produce no done pulse.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package gcd_pkg SHALL hold the state enum (3-bit encoding) and the default WIDTH constant.
REQ-030 Control SHALL use one registered state plus a combinational next-state block; the datapath registers are a, b, k and result.
REQ-031 The block SHALL be implemented with no sub-module; shifter and subtractor are inline.

Verification
REQ-032 n1=48, n2=18, start pulse -> single done pulse, result=6, zero_in=0, busy high from the cycle after start until done.
REQ-033 n1=0, n2=7 -> result=7, done within 3 cycles of start; then n1=0, n2=0 -> result=0, zero_in=1.
REQ-034 n1=0x80000000, n2=0x40000000 -> result=0x40000000; n1=n2=17 -> result=17.
REQ-035 n1=0xFFFFFFFF, n2=0xFFFFFFFE -> result=1, latency <= 132 cycles.
REQ-036 n1=48, n2=18; 5 cycles later new start with n1=9, n2=3 -> ignored, result=6.
REQ-037 Reset and restart -> rst asserted mid-LOOP: no done, result=0, IDLE next cycle; a following start with n1=12, n2=8 -> result=4.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state encoding and default operand width for the binary GCD block
package gcd_pkg;
  localparam int GCD_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, CHECK, STRIP, ODD_A, LOOP, FINISH, DONE} gcd_state_t;
endpackage

// File: rtl/gcd_binary.sv
// gcd_binary: iterative Stein binary GCD using only shifts, compares and subtracts
module gcd_binary
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_in
);
  localparam int KW = $clog2(WIDTH) + 1;
  gcd_state_t state, nxt;
  logic [WIDTH-1:0] a, b;
  logic [KW-1:0] k;
  logic any_zero, both_even;
  assign any_zero = (a == '0) || (b == '0);
  assign both_even = !a[0] && !b[0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CHECK : IDLE;
      CHECK:   nxt = any_zero ? DONE : STRIP;
      STRIP:   nxt = both_even ? STRIP : ODD_A;
      ODD_A:   nxt = a[0] ? LOOP : ODD_A;
      LOOP:    nxt = (b[0] && a == b) ? FINISH : LOOP;
      FINISH:  nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // a stays odd once LOOP is entered, so the swap keeps the larger value as minuend
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      k <= '0;
      result <= '0;
      zero_in <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= n1;
          b <= n2;
          k <= '0;
          zero_in <= 1'b0;
        end
        CHECK: if (any_zero) begin
          result <= a | b;
          zero_in <= (a | b) == '0;
        end
        STRIP: if (both_even) begin
          a <= a >> 1;
          b <= b >> 1;
          k <= k + 1'b1;
        end
        ODD_A: if (!a[0]) a <= a >> 1;
        LOOP:
          if (!b[0]) b <= b >> 1;
          else if (a > b) begin
            a <= b;
            b <= a - b;
          end else if (a != b) b <= b - a;
        FINISH: result <= a << k;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_binary.sv
// tb_gcd_binary: randomized and directed checks of gcd_binary against a Euclid reference model
module tb_gcd_binary;
  localparam int W = 32;
  localparam int LMAX = 4 * W + 4;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] n1 = 0, n2 = 0, result;
  logic busy, done, zero_in;
  int compared = 0, mismatched = 0;
  logic active = 0, job_zero = 0, exp_zero = 0;
  logic [W-1:0] job_res = 0, exp_res = 0;
  int cyc = 0;

  gcd_binary #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .n1(n1), .n2(n2),
    .busy(busy), .done(done), .result(result), .zero_in(zero_in)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // job-level model: one job per accepted start, finished when the DUT reports done
  always @(posedge clk) begin
    if (rst) begin
      active = 0;
      exp_res = 0;
      exp_zero = 0;
    end else if (active && done) begin
      active = 0;
      exp_res = job_res;
      exp_zero = job_zero;
    end else if (!active && start) begin
      active = 1;
      job_res = gcd(n1, n2);
      job_zero = (n1 == 0) && (n2 == 0);
      cyc = 0;
    end
    if (active) cyc++;
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, active});
    if (done) begin
      chk("done_in_job", 64'd1, {63'd0, active});
      chk("result", {32'd0, result}, {32'd0, job_res});
      chk("zero_in", {63'd0, zero_in}, {63'd0, job_zero});
      chk("latency_bound", {63'd0, cyc <= LMAX}, 64'd1);
    end else if (!active) begin
      chk("result_hold", {32'd0, result}, {32'd0, exp_res});
      chk("zero_hold", {63'd0, zero_in}, {63'd0, exp_zero});
    end
  end

  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise, output int lat);
    int t = 0;
    while (busy && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    n1 = x; n2 = y; start = 1;
    @(posedge clk); #1;
    start = 0; n1 = $urandom; n2 = $urandom;
    lat = 1;
    while (!done && lat < 300) begin
      if (noise) begin
        start = $urandom_range(0, 3) == 0;
        n1 = $urandom; n2 = $urandom;
      end
      @(posedge clk); #1; lat++;
    end
    start = 0;
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] x, y;
    chk("model_48_18", {32'd0, gcd(48, 18)}, 64'd6);
    chk("model_0_0", {32'd0, gcd(0, 0)}, 64'd0);
    chk("model_12_8", {32'd0, gcd(12, 8)}, 64'd4);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    rst = 0;
    @(posedge clk); #1;
    go(48, 18, 0, lat);
    chk("r_48_18", {32'd0, result}, 64'd6);
    chk("z_48_18", {63'd0, zero_in}, 64'd0);
    go(0, 7, 0, lat);
    chk("r_0_7", {32'd0, result}, 64'd7);
    chk("lat_0_7", {63'd0, lat <= 3}, 64'd1);
    go(0, 0, 0, lat);
    chk("r_0_0", {32'd0, result}, 64'd0);
    chk("z_0_0", {63'd0, zero_in}, 64'd1);
    go(32'h8000_0000, 32'h4000_0000, 0, lat);
    chk("r_pow2", {32'd0, result}, 64'h4000_0000);
    go(17, 17, 0, lat);
    chk("r_17", {32'd0, result}, 64'd17);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, lat);
    chk("r_ff", {32'd0, result}, 64'd1);
    chk("lat_ff", {63'd0, lat <= 132}, 64'd1);
    @(posedge clk); #1;
    n1 = 48; n2 = 18; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    n1 = 9; n2 = 3; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    while (!done && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    chk("r_ignore", {32'd0, result}, 64'd6);
    @(posedge clk); #1;
    n1 = 32'hFFFF_FFFF; n2 = 32'hFFFF_FFFE; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    go(12, 8, 0, lat);
    chk("r_12_8", {32'd0, result}, 64'd4);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = $urandom_range(0, 40); y = $urandom_range(0, 40); end
        2: begin
          x = $urandom_range(1, 5000) << $urandom_range(0, 20);
          y = $urandom_range(1, 5000) << $urandom_range(0, 20);
        end
        default: begin
          x = $urandom_range(1, 999);
          y = x * $urandom_range(1, 999);
        end
      endcase
      go(x, y, i[0], lat);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
